// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM/divider state types and default widths for the PWM blocks
package pwm_pkg;
    localparam int CNT_W_DEF  = 32;
    localparam int DUTY_W_DEF = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} pwm_state_t;
    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
endpackage

// File: rtl/pwm_divider.sv
// pwm_divider: restoring divider, one quotient bit per cycle, truncated quotient
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_start           load operands and begin (ignored while busy)
//   i_abort           drop any divide in progress
//   i_num, i_den      numerator / denominator (denominator must be nonzero)
//   o_busy            divide in progress
//   o_done            final iteration this cycle; o_quot is valid alongside it
//   o_quot            low Q_W bits of the quotient
module pwm_divider
    import pwm_pkg::*;
#(
    parameter int NUM_W = 40,
    parameter int DEN_W = 32,
    parameter int Q_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot
);
    localparam int CW = $clog2(NUM_W + 1);
    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [NUM_W-1:0] r_num;
    logic [DEN_W-1:0] r_den;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W:0]   w_shift;
    logic [DEN_W:0]   w_diff;
    logic             w_ge;
    logic [NUM_W-1:0] w_num_n;
    // Remainder stays below the denominator, so the trial difference fits in
    // DEN_W+1 bits and its top bit is the borrow.
    always_comb begin
        w_shift = {r_rem, r_num[NUM_W-1]};
        w_diff  = w_shift - {1'b0, r_den};
        w_ge    = ~w_diff[DEN_W];
        w_num_n = {r_num[NUM_W-2:0], w_ge};
    end
    assign o_busy = r_state == DIV_BUSY;
    assign o_done = o_busy && r_cnt == CW'(1);
    assign o_quot = w_num_n[Q_W-1:0];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_num   <= '0;
            r_den   <= '0;
            r_rem   <= '0;
        end else if (i_abort) begin
            r_state <= DIV_IDLE;
        end else if (i_start && !o_busy) begin
            r_state <= DIV_BUSY;
            r_cnt   <= CW'(NUM_W);
            r_num   <= i_num;
            r_den   <= i_den;
            r_rem   <= '0;
        end else if (o_busy) begin
            r_num   <= w_num_n;
            r_rem   <= w_ge ? w_diff[DEN_W-1:0] : w_shift[DEN_W-1:0];
            r_cnt   <= r_cnt - CW'(1);
            r_state <= o_done ? DIV_IDLE : DIV_BUSY;
        end
    end
endmodule

// File: rtl/pwm_detector.sv
// pwm_detector: measures PWM high time, period and 0..2^DUTY_W-1 duty, flags stuck input
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_pwm_in           asynchronous PWM input
//   o_high_count       high cycles of the last complete period
//   o_period_count     cycles between the last two rising edges
//   o_duty             floor(high * (2^DUTY_W-1) / period)
//   o_meas_valid       one-cycle pulse when duty/high/period form a new set
//   o_stuck_high/low   no edge for TIMEOUT cycles at the given level
//   o_overrun          sticky: a period completed while the divider was busy
module pwm_detector
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pwm_in,
    output logic [CNT_W-1:0]  o_high_count,
    output logic [CNT_W-1:0]  o_period_count,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_meas_valid,
    output logic              o_stuck_high,
    output logic              o_stuck_low,
    output logic              o_overrun
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = CNT_W + DUTY_W;
    logic               r_s1, r_s2, r_s3;
    logic [TW-1:0]      r_tmo;
    pwm_state_t         r_state;
    logic [CNT_W-1:0]   r_hi, r_per;
    logic               w_rise, w_fall, w_edge, w_to, w_complete, w_start;
    logic               w_busy, w_done;
    logic [DUTY_W-1:0]  w_quot;
    logic [NW-1:0]      w_num;
    assign w_rise     = r_s2 & ~r_s3;
    assign w_fall     = ~r_s2 & r_s3;
    assign w_edge     = r_s2 ^ r_s3;
    // Fires once, on the cycle the idle counter would reach TIMEOUT.
    assign w_to       = !w_edge && r_tmo == TW'(TIMEOUT - 1);
    assign w_complete = w_rise && r_state == ST_LOW;
    assign w_start    = w_complete && !w_busy;
    assign w_num      = {r_hi, {DUTY_W{1'b0}}} - {{DUTY_W{1'b0}}, r_hi};
    pwm_divider #(.NUM_W(NW), .DEN_W(CNT_W), .Q_W(DUTY_W)) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_abort (w_to),
        .i_num   (w_num),
        .i_den   (r_per),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_quot  (w_quot)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {r_s1, r_s2, r_s3} <= '0;
            r_tmo          <= '0;
            r_state        <= ST_IDLE;
            r_hi           <= '0;
            r_per          <= '0;
            o_high_count   <= '0;
            o_period_count <= '0;
            o_duty         <= '0;
            o_meas_valid   <= 1'b0;
            o_stuck_high   <= 1'b0;
            o_stuck_low    <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            r_s1         <= i_pwm_in;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_tmo        <= w_edge ? '0 : (r_tmo != TW'(TIMEOUT) ? r_tmo + TW'(1) : r_tmo);
            o_meas_valid <= w_to || w_done;
            if (w_to) begin
                r_state        <= ST_IDLE;
                o_stuck_high   <= r_s2;
                o_stuck_low    <= !r_s2;
                o_high_count   <= '0;
                o_period_count <= '0;
                o_duty         <= {DUTY_W{r_s2}};
            end else begin
                if (w_done) begin
                    o_duty       <= w_quot;
                    o_stuck_high <= 1'b0;
                    o_stuck_low  <= 1'b0;
                end
                if (w_start) begin
                    o_high_count   <= r_hi;
                    o_period_count <= r_per;
                end
                if (w_complete && w_busy)
                    o_overrun <= 1'b1;
                if (w_rise) begin
                    r_state <= ST_HIGH;
                    r_hi    <= CNT_W'(1);
                    r_per   <= CNT_W'(1);
                end else begin
                    if (w_fall && r_state == ST_HIGH)
                        r_state <= ST_LOW;
                    if (r_state != ST_IDLE && r_per != '1)
                        r_per <= r_per + CNT_W'(1);
                    // The falling-edge cycle already sees the level low, so it is not counted high.
                    if (r_state == ST_HIGH && r_s2 && r_hi != '1)
                        r_hi <= r_hi + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_detector.sv
// tb_pwm_detector: directed self-checking bench for pwm_detector
module tb_pwm_detector;
    localparam int CW = 32;
    localparam int DW = 8;
    localparam int TO = 300;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm = 1'b0;
    logic [CW-1:0] high_count, period_count;
    logic [DW-1:0] duty;
    logic          mv, sh, sl, ov;
    int            cyc = 0;
    int            mv_cnt = 0;
    int            mv_cyc = 0;
    logic [DW-1:0] cap_duty = '0;
    logic          cap_sh = 1'b0;
    int            n_pass = 0;
    int            n_chk = 0;
    int            rise_cyc = 0;
    int            base = 0;
    int            prev_mv = 0;
    always #5 clk = ~clk;
    pwm_detector #(.CNT_W(CW), .DUTY_W(DW), .TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pwm_in       (pwm),
        .o_high_count   (high_count),
        .o_period_count (period_count),
        .o_duty         (duty),
        .o_meas_valid   (mv),
        .o_stuck_high   (sh),
        .o_stuck_low    (sl),
        .o_overrun      (ov)
    );
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mv) begin
            mv_cnt   = mv_cnt + 1;
            mv_cyc   = cyc;
            cap_duty = duty;
            cap_sh   = sh;
        end
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask
    task automatic check_zero(input string p);
        chk({p, "_high"}, 64'(high_count), 0);
        chk({p, "_period"}, 64'(period_count), 0);
        chk({p, "_duty"}, 64'(duty), 0);
        chk({p, "_mv"}, 64'(mv), 0);
        chk({p, "_sh"}, 64'(sh), 0);
        chk({p, "_sl"}, 64'(sl), 0);
        chk({p, "_ov"}, 64'(ov), 0);
    endtask
    task automatic period(input int h, input int l);
        pwm = 1'b1;
        rise_cyc = cyc;
        repeat (h) @(negedge clk);
        pwm = 1'b0;
        repeat (l) @(negedge clk);
    endtask
    task automatic hold(input logic v, input int n);
        pwm = v;
        repeat (n) @(negedge clk);
    endtask
    initial begin
        @(negedge clk);
        repeat (6) begin
            pwm = ~pwm;
            @(negedge clk);
        end
        check_zero("reset");
        pwm = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        base = mv_cnt;
        period(64, 192);
        chk("first_period_no_mv", 64'(mv_cnt - base), 0);
        period(64, 192);
        chk("steady_mv_count", 64'(mv_cnt - base), 1);
        chk("steady_latency", 64'(mv_cyc - rise_cyc), 43);
        chk("steady_cap_duty", 64'(cap_duty), 63);
        chk("steady_high", 64'(high_count), 64);
        chk("steady_period", 64'(period_count), 256);
        prev_mv = mv_cyc;
        period(64, 192);
        chk("steady_interval", 64'(mv_cyc - prev_mv), 256);
        chk("steady_mv_count2", 64'(mv_cnt - base), 2);
        base = mv_cnt;
        hold(1'b1, 320);
        chk("sh_mv_count", 64'(mv_cnt - base), 2);
        chk("sh_flag", 64'(sh), 1);
        chk("sh_low_flag", 64'(sl), 0);
        chk("sh_duty", 64'(duty), 255);
        chk("sh_high", 64'(high_count), 0);
        chk("sh_period", 64'(period_count), 0);
        chk("sh_cap_flag", 64'(cap_sh), 1);
        base = mv_cnt;
        hold(1'b0, 192);
        period(64, 192);
        chk("sh_persist", 64'(sh), 1);
        chk("sh_resume_no_mv", 64'(mv_cnt - base), 0);
        period(64, 192);
        chk("sh_cleared", 64'(sh), 0);
        chk("sh_resume_duty", 64'(duty), 63);
        chk("sh_resume_mv", 64'(mv_cnt - base), 1);
        base = mv_cnt;
        hold(1'b0, 320);
        chk("sl_flag", 64'(sl), 1);
        chk("sl_high_flag", 64'(sh), 0);
        chk("sl_duty", 64'(duty), 0);
        chk("sl_high", 64'(high_count), 0);
        chk("sl_period", 64'(period_count), 0);
        chk("sl_mv_count", 64'(mv_cnt - base), 1);
        chk("ov_before", 64'(ov), 0);
        base = mv_cnt;
        repeat (12) period(5, 5);
        hold(1'b0, 60);
        chk("ov_flag", 64'(ov), 1);
        chk("ov_mv_count", 64'(mv_cnt - base), 3);
        chk("ov_duty", 64'(duty), 127);
        chk("ov_high", 64'(high_count), 5);
        chk("ov_period", 64'(period_count), 10);
        chk("ov_sl_cleared", 64'(sl), 0);
        hold(1'b0, 100);
        chk("ov_sticky", 64'(ov), 1);
        period(64, 192);
        base = mv_cnt;
        pwm = 1'b1;
        repeat (23) @(negedge clk);
        rst = 1'b1;
        pwm = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("middiv");
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("middiv_no_mv", 64'(mv_cnt - base), 0);
        period(64, 192);
        period(64, 192);
        chk("restart_mv", 64'(mv_cnt - base), 1);
        chk("restart_latency", 64'(mv_cyc - rise_cyc), 43);
        chk("restart_duty", 64'(duty), 63);
        chk("restart_high", 64'(high_count), 64);
        chk("restart_period", 64'(period_count), 256);
        chk("restart_ov", 64'(ov), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
